// File: rtl/cvp_pkg.sv
// Shared types for the vector memory sequencer.
// Holds the transfer FSM encoding and the stride width.
package cvp_pkg;

    localparam int STRIDE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } vstate_e;

endpackage

// File: rtl/vec_addr_gen.sv
// Combinational element address generator: base + idx*stride.
// Ports: base_i, stride_i (signed), idx_i -> addr_o (wrapped), wrap_o.
module vec_addr_gen
    import cvp_pkg::*;
#(
    parameter int AW = 16,
    parameter int CW = 4
) (
    input  logic [AW-1:0]       base_i,
    input  logic [STRIDE_W-1:0] stride_i,
    input  logic [CW-1:0]       idx_i,
    output logic [AW-1:0]       addr_o,
    output logic                wrap_o
);

    // Wide enough that base + idx*stride never overflows, so any bit
    // above AW (including the sign) means the address left [0, 2^AW-1].
    localparam int WW = AW + CW + STRIDE_W + 1;

    logic signed [WW-1:0] base_x;
    logic signed [WW-1:0] idx_x;
    logic signed [WW-1:0] str_x;
    logic signed [WW-1:0] full;

    always_comb begin
        base_x = {{(WW-AW){1'b0}}, base_i};
        idx_x  = {{(WW-CW){1'b0}}, idx_i};
        str_x  = {{(WW-STRIDE_W){stride_i[STRIDE_W-1]}}, stride_i};
        full   = base_x + idx_x * str_x;
    end

    assign addr_o = full[AW-1:0];
    assign wrap_o = |full[WW-1:AW];

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: walks count+1 strided elements over a
// single-beat memory port. Ports: start/is_store/base_addr/stride/count/
// st_vec request; Addr/RD/WR/dataOut/DataIn/MemRdy memory side;
// ld_vec result, busy, done pulse, V address-wrap flag.
module vec_mem_seq
    import cvp_pkg::*;
#(
    parameter int EW    = 16,
    parameter int NELEM = 16,
    parameter int AW    = 16,
    parameter int CW    = $clog2(NELEM)
) (
    input  logic                Clk1,
    input  logic                Reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [AW-1:0]       base_addr,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [CW-1:0]       count,
    input  logic [EW*NELEM-1:0] st_vec,
    input  logic [EW-1:0]       DataIn,
    input  logic                MemRdy,
    output logic [AW-1:0]       Addr,
    output logic                RD,
    output logic                WR,
    output logic [EW-1:0]       dataOut,
    output logic [EW*NELEM-1:0] ld_vec,
    output logic                busy,
    output logic                done,
    output logic                V
);

    vstate_e               state_q;
    logic                  is_store_q;
    logic [AW-1:0]         base_q;
    logic [STRIDE_W-1:0]   stride_q;
    logic [CW-1:0]         count_q;
    logic [EW*NELEM-1:0]   st_vec_q;
    logic [CW-1:0]         idx_q;
    logic [EW*NELEM-1:0]   ld_vec_q;
    logic                  v_q;

    logic [AW-1:0]         gen_addr;
    logic                  gen_wrap;
    logic                  xfer;

    vec_addr_gen #(
        .AW (AW),
        .CW (CW)
    ) u_addr_gen (
        .base_i   (base_q),
        .stride_i (stride_q),
        .idx_i    (idx_q),
        .addr_o   (gen_addr),
        .wrap_o   (gen_wrap)
    );

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            st_vec_q   <= '0;
            idx_q      <= '0;
            ld_vec_q   <= '0;
            v_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= XFER;
                        is_store_q <= is_store;
                        base_q     <= base_addr;
                        stride_q   <= stride;
                        count_q    <= count;
                        st_vec_q   <= st_vec;
                        idx_q      <= '0;
                        v_q        <= 1'b0;
                        if (!is_store) begin
                            ld_vec_q <= '0;
                        end
                    end
                end
                XFER: begin
                    // Wrap is sticky for the whole transfer; a stalled
                    // beat re-presents the same address, so this is safe.
                    if (gen_wrap) begin
                        v_q <= 1'b1;
                    end
                    if (MemRdy) begin
                        if (!is_store_q) begin
                            ld_vec_q[idx_q*EW +: EW] <= DataIn;
                        end
                        if (idx_q == count_q) begin
                            state_q <= FIN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign xfer    = (state_q == XFER);
    assign Addr    = xfer ? gen_addr : '0;
    assign RD      = xfer & ~is_store_q;
    assign WR      = xfer & is_store_q;
    assign dataOut = WR ? st_vec_q[idx_q*EW +: EW] : '0;
    assign ld_vec  = ld_vec_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign V       = v_q;

endmodule
